ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, instruction address width (matches `ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width (matches `DATA_WIDTH).
REQ-003 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries, power of two, >=2.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port fetch_en  input  1  permits new memory requests when high.
REQ-008 SHALL have port redir_valid  input  1  branch/jump redirect strobe.
REQ-009 SHALL have port redir_addr  input  ADDR_WIDTH  redirect target address.
REQ-010 SHALL have port ifu_rd_req  output  1  memory read request, one word per cycle.
REQ-011 SHALL have port ifu_rd_addr  output  ADDR_WIDTH  memory read address.
REQ-012 SHALL have port ifu_rd_data  input  DATA_WIDTH  memory data, valid the cycle after ifu_rd_req.
REQ-013 SHALL have port dec_valid  output  1  buffer head holds a valid instruction.
REQ-014 SHALL have port dec_instr  output  DATA_WIDTH  instruction word at buffer head.
REQ-015 SHALL have port dec_pc  output  ADDR_WIDTH  address of dec_instr.
REQ-016 SHALL have port dec_ready  input  1  decoder accepts head when high with dec_valid.

Function
REQ-017 SHALL hold pc (next fetch address), inflight flag, inflight address, FIFO of {instr, pc} with count 0..FIFO_DEPTH.
REQ-018 SHALL use two states: IDLE (no requests) and RUN; IDLE->RUN when fetch_en=1, RUN->IDLE when fetch_en=0, evaluated each cycle.
REQ-019 SHALL drive ifu_rd_req=1 combinationally iff fetch_en=1, redir_valid=0, rst=0, and count+inflight < FIFO_DEPTH.
REQ-020 SHALL drive ifu_rd_addr=pc at all times; on an issued request pc advances by 1, wrapping modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000 at default width).
REQ-021 SHALL set inflight=1 and latch inflight address on the edge ending a request cycle; otherwise set inflight=0.
REQ-022 SHALL write {ifu_rd_data, inflight address} to FIFO tail on the edge ending a cycle with inflight=1 and redir_valid=0.
REQ-023 SHALL have request-to-dec_valid latency of exactly 2 cycles with empty FIFO; no bypass path.
REQ-024 SHALL pop head on each cycle with dec_valid=1 and dec_ready=1; simultaneous push and pop leave count unchanged.
REQ-025 SHALL drive dec_valid=(count!=0); dec_instr/dec_pc SHALL be stable while dec_valid=1 and dec_ready=0.
REQ-026 SHALL sustain one request and one pop per cycle in steady state when dec_ready=1 and fetch_en=1.
REQ-027 SHALL never overflow: the credit rule of REQ-019 guarantees a push never occurs with count=FIFO_DEPTH.
REQ-028 SHALL, when redir_valid=1: clear FIFO (count=0), discard the inflight response, set inflight=0, load pc=redir_addr, suppress ifu_rd_req that cycle.
REQ-029 SHALL give redirect priority over push, pop and fetch_en; a simultaneous dec handshake counts as consumed, head discarded.
REQ-030 SHALL issue the first post-redirect request at redir_addr the following cycle if REQ-019 conditions hold.
REQ-031 SHALL, when fetch_en falls with inflight=1, still capture that response; no further requests issue.

Reset
REQ-032 SHALL, on rst=1 at a rising edge: pc=RESET_PC, state=IDLE, inflight=0, count=0.
REQ-033 SHALL hold ifu_rd_req=0 and dec_valid=0 during any cycle with rst=1; reset mid-operation discards FIFO contents and any inflight response.
REQ-034 SHALL leave dec_instr/dec_pc values unspecified while dec_valid=0.

Verification
REQ-035 SHALL verify: reset release, fetch_en=1, dec_ready=1 -> requests addr 0x0000,0x0001,... every cycle; dec_valid first high 2 cycles after first request, dec_pc=0x0000.
REQ-036 SHALL verify: dec_ready=0 held -> exactly 4 requests total, FIFO full, ifu_rd_req=0; dec_ready=1 -> in-order dec_pc 0x0000..0x0003, requests resume.
REQ-037 SHALL verify: redir_valid=1 with redir_addr=0x1234, FIFO nonempty and inflight=1 -> next cycle dec_valid=0, next request addr 0x1234, no stale word ever reaches decoder.
REQ-038 SHALL verify: redirect to 0xFFFE -> request sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-039 SHALL verify: fetch_en dropped for 3 cycles mid-stream -> no requests in that window, inflight word delivered, sequence continues with no gap or duplicate.
REQ-040 SHALL verify: rst=1 asserted with FIFO at 3 entries -> next cycle dec_valid=0, ifu_rd_req=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues sequential word reads, buffers responses in a
// small FIFO with their addresses, and flushes everything on a redirect.
module ifu_fetch #(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_addr,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  dec_valid,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] infl_addr_q, infl_addr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

    logic credit_ok;
    logic push;
    logic pop;

    // Credit counts both buffered words and the one still in flight, so a push never overflows
    assign credit_ok   = (count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);
    assign ifu_rd_req  = fetch_en & ~redir_valid & ~rst & credit_ok;
    assign ifu_rd_addr = pc_q;

    assign dec_valid   = (count_q != '0) & ~rst;
    assign dec_instr   = instr_mem[rd_ptr_q];
    assign dec_pc      = pc_mem[rd_ptr_q];

    assign push        = inflight_q & ~redir_valid;
    assign pop         = dec_valid & dec_ready & ~redir_valid;

    // Run/idle tracking follows fetch_en every cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        inflight_d  = 1'b0;
        infl_addr_d = infl_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (redir_valid) begin
            // Redirect drops the buffer and the pending response in one cycle
            pc_d     = redir_addr;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (ifu_rd_req) begin
                pc_d        = pc_q + ADDR_WIDTH'(1);
                inflight_d  = 1'b1;
                infl_addr_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem[wr_ptr_q] <= ifu_rd_data;
            pc_mem[wr_ptr_q]    <= infl_addr_q;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: scenario tasks plus a scoreboard that tracks every issued
// fetch as an outstanding item and predicts request/decode behaviour from it.
module tb_ifu_fetch;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RPC = 16'h0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redir_valid = 1'b0;
    logic [AW-1:0] redir_addr = '0;
    logic          ifu_rd_req;
    logic [AW-1:0] ifu_rd_addr;
    logic [DW-1:0] ifu_rd_data = '0;
    logic          dec_valid;
    logic [DW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic          dec_ready = 1'b0;

    ifu_fetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC  (RPC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .redir_valid(redir_valid),
        .redir_addr (redir_addr),
        .ifu_rd_req (ifu_rd_req),
        .ifu_rd_addr(ifu_rd_addr),
        .ifu_rd_data(ifu_rd_data),
        .dec_valid  (dec_valid),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc),
        .dec_ready  (dec_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } item_t;

    item_t         sb[$];
    logic [AW-1:0] exp_pc = RPC;
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    logic          last_req = 1'b0;
    logic [AW-1:0] last_addr = '0;

    logic          obs_req, obs_valid;
    logic [AW-1:0] obs_addr, obs_pc;
    logic [DW-1:0] obs_instr;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    // Items the decoder may see next cycle: issued at least two cycles before it
    function automatic int visible();
        int n = 0;
        foreach (sb[i]) if (sb[i].cyc + 2 <= cyc) n++;
        return n;
    endfunction

    // One clock: memory response, sample outputs, scoreboard compare, model update
    task automatic step();
        logic exp_req, exp_valid;
        @(negedge clk);
        ifu_rd_data = last_req ? word(last_addr) : DW'($urandom);
        #1;
        obs_req   = ifu_rd_req;
        obs_addr  = ifu_rd_addr;
        obs_valid = dec_valid;
        obs_pc    = dec_pc;
        obs_instr = dec_instr;
        exp_req   = !rst && fetch_en && !redir_valid && (sb.size() < DEPTH);
        exp_valid = !rst && (sb.size() != 0) && (sb[0].cyc + 2 <= cyc);
        tests++;
        if (obs_req !== exp_req) begin
            fails++;
            $display("FAIL sb_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req);
        end
        tests++;
        if (obs_valid !== exp_valid) begin
            fails++;
            $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid);
        end
        if (exp_req && obs_req) begin
            tests++;
            if (obs_addr !== exp_pc) begin
                fails++;
                $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_pc);
            end
        end
        if (exp_valid && obs_valid) begin
            tests++;
            if (obs_pc !== sb[0].addr || obs_instr !== word(sb[0].addr)) begin
                fails++;
                $display("FAIL sb_dec cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_instr,
                         sb[0].addr, word(sb[0].addr));
            end
        end
        if (rst) begin
            sb.delete();
            exp_pc = RPC;
        end else if (redir_valid) begin
            sb.delete();
            exp_pc = redir_addr;
        end else begin
            if (exp_valid && dec_ready) void'(sb.pop_front());
            if (exp_req) begin
                sb.push_back('{addr: exp_pc, cyc: cyc});
                exp_pc = exp_pc + AW'(1);
            end
        end
        last_req  = obs_req;
        last_addr = obs_addr;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b1; dec_ready = 1'b1;
        step(); step();
        tests++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got=%b%b exp=00", obs_req, obs_valid);
        end
        rst = 1'b0;
        step();
        tests++;
        if (obs_req !== 1'b1 || obs_addr !== RPC) begin
            fails++;
            $display("FAIL reset_first_req got=%b/%h exp=1/%h", obs_req, obs_addr, RPC);
        end
    endtask

    task automatic test_stream();
        int first_req = -1, first_valid = -1, nreq = 0;
        logic [AW-1:0] first_addr = '1, first_vpc = '1;
        fetch_en = 1'b0; dec_ready = 1'b1;
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (obs_req) nreq++;
            if (obs_req && first_req < 0) begin first_req = i; first_addr = obs_addr; end
            if (obs_valid && first_valid < 0) begin first_valid = i; first_vpc = obs_pc; end
        end
        tests++;
        if (first_valid - first_req != 2 || first_addr !== 16'h0000 || first_vpc !== 16'h0000) begin
            fails++;
            $display("FAIL stream_latency got=%0d/%h/%h exp=2/0000/0000",
                     first_valid - first_req, first_addr, first_vpc);
        end
        tests++;
        if (nreq != 12) begin
            fails++;
            $display("FAIL stream_rate got=%0d exp=12", nreq);
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        logic [AW-1:0] got[$];
        logic resumed = 1'b0;
        fetch_en = 1'b1; dec_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_req) nreq++;
        end
        tests++;
        if (nreq != 4 || obs_req !== 1'b0 || obs_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_full got=%0d/%b/%b exp=4/0/1", nreq, obs_req, obs_valid);
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_valid) got.push_back(obs_pc);
            if (obs_req) resumed = 1'b1;
        end
        tests++;
        if (got.size() < 4 || got[0] !== 16'h0 || got[1] !== 16'h1 ||
            got[2] !== 16'h2 || got[3] !== 16'h3 || !resumed) begin
            fails++;
            $display("FAIL bp_drain got=%0d items resumed=%b exp=0..3 resumed=1", got.size(), resumed);
        end
    endtask

    task automatic test_redirect();
        dec_ready = 1'b0; fetch_en = 1'b1;
        step(); step();
        redir_valid = 1'b1; redir_addr = 16'h1234;
        step();
        redir_valid = 1'b0; dec_ready = 1'b1;
        step();
        tests++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 16'h1234) begin
            fails++;
            $display("FAIL redirect got=%b/%b/%h exp=0/1/1234", obs_valid, obs_req, obs_addr);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a[3];
        fetch_en = 1'b1; dec_ready = 1'b1;
        redir_valid = 1'b1; redir_addr = 16'hFFFE;
        step();
        redir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            a[i] = obs_req ? obs_addr : 16'hDEAD;
        end
        tests++;
        if (a[0] !== 16'hFFFE || a[1] !== 16'hFFFF || a[2] !== 16'h0000) begin
            fails++;
            $display("FAIL wrap got=%h,%h,%h exp=fffe,ffff,0000", a[0], a[1], a[2]);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_fetch_pause();
        int nreq = 0;
        fetch_en = 1'b1; dec_ready = 1'b1;
        step(); step();
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs_req) nreq++;
        end
        tests++;
        if (nreq != 0) begin
            fails++;
            $display("FAIL pause_reqs got=%0d exp=0", nreq);
        end
        fetch_en = 1'b1;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset_mid();
        fetch_en = 1'b1; dec_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10 && visible() < 3; i++) step();
        rst = 1'b1;
        step();
        tests++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid got=%b/%b exp=0/0", obs_valid, obs_req);
        end
        rst = 1'b0; dec_ready = 1'b1;
        step();
        tests++;
        if (obs_req !== 1'b1 || obs_addr !== RPC || obs_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_restart got=%b/%h/%b exp=1/%h/0", obs_req, obs_addr, obs_valid, RPC);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            fetch_en    = ($urandom_range(99) < 80);
            dec_ready   = ($urandom_range(99) < 70);
            redir_valid = ($urandom_range(99) < 5);
            redir_addr  = AW'($urandom);
            rst         = ($urandom_range(99) < 1);
            step();
        end
        rst = 1'b0; redir_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_pause();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
